// File: rtl/axi4_frame_reader.sv
// ---------------------------------------------------------------------------------------------
// axi4_frame_reader
//
// AXI4 read master that fetches one 320x240 RGB565 frame (FRAME_BYTES) from one of two DDR
// frame buffers and streams it out as 64-bit beats toward the HDMI output FIFO. The frame is
// read as fixed INCR bursts of 64 beats x 8 bytes. A burst is only requested once the
// downstream FIFO reports room for all 64 beats, so read data is passed through
// combinationally with no local buffering.
//
// Ports
//   clk_100Mhz, rst_n          single clock, synchronous active-low reset
//   start_frame, buf_select    frame request (rising edge) and buffer choice latched on it
//   room_ok                    downstream FIFO has >= 64 free entries (sampled in IDLE only)
//   AR*                        AXI4 read address channel (fixed burst shape and attributes)
//   R*                         AXI4 read data channel
//   m_data/m_valid/m_ready     output stream, m_sof marks the first beat of a frame
//   reader_done                one-cycle pulse once the last burst of a frame has finished
//   rresp_err, rlast_err       sticky error flags, cleared by reset only
//   state, ADDR_OFFSET         FSM state and current burst byte offset, for debug
// ---------------------------------------------------------------------------------------------
module axi4_frame_reader #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned FRAME_BYTES    = 153600
) (
    input  logic                      clk_100Mhz,
    input  logic                      rst_n,
    input  logic                      start_frame,
    input  logic                      buf_select,
    input  logic                      room_ok,
    output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    output logic [7:0]                ARLEN,
    output logic [2:0]                ARSIZE,
    output logic [1:0]                ARBURST,
    output logic [3:0]                ARCACHE,
    output logic [2:0]                ARPROT,
    input  logic [AXI_DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]                RRESP,
    input  logic                      RLAST,
    input  logic                      RVALID,
    output logic                      RREADY,
    output logic [AXI_DATA_WIDTH-1:0] m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_sof,
    output logic                      reader_done,
    output logic                      rresp_err,
    output logic                      rlast_err,
    output logic [1:0]                state,
    output logic [31:0]               ADDR_OFFSET
);

    // FSM encoding is visible on the debug port, so it is fixed here
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ADDR_SEND = 2'd1;
    localparam logic [1:0] DATA_RECV = 2'd2;
    localparam logic [1:0] FRAME_END = 2'd3;

    localparam logic [31:0] BURST_BYTES = 32'd512;
    localparam logic [31:0] LAST_OFFSET = 32'(FRAME_BYTES) - BURST_BYTES;
    localparam logic [31:0] BASE_BUF1   = 32'h0100_0000;
    localparam logic [31:0] BASE_BUF0   = 32'h0110_0000;
    localparam logic [5:0]  LAST_BEAT   = 6'd63;

    // -----------------------------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------------------------
    logic [1:0]                r_state;
    logic                      r_start_d;
    logic                      r_buf_select;
    logic                      r_active;
    logic                      r_restart_pending;
    logic                      r_restart_buf;
    logic [31:0]               r_addr_offset;
    logic [AXI_ADDR_WIDTH-1:0] r_araddr;
    logic                      r_arvalid;
    logic [5:0]                r_beat_count;
    logic                      r_rresp_err;
    logic                      r_rlast_err;

    // -----------------------------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------------------------
    logic        w_start_edge;
    logic        w_in_data;
    logic        w_beat;
    logic        w_burst_end;
    logic [31:0] w_base;
    logic        w_restart;
    logic        w_restart_buf;

    always_comb begin
        w_start_edge  = start_frame & ~r_start_d;
        w_in_data     = (r_state == DATA_RECV);
        w_beat        = w_in_data & RVALID & m_ready;
        w_burst_end   = w_beat & (r_beat_count == LAST_BEAT);
        w_base        = r_buf_select ? BASE_BUF1 : BASE_BUF0;
        // A restart can be pending from earlier or arrive on the very cycle it is applied
        w_restart     = r_restart_pending | w_start_edge;
        w_restart_buf = w_start_edge ? buf_select : r_restart_buf;
    end

    // -----------------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------------
    always_comb begin
        ARADDR      = r_araddr;
        ARVALID     = r_arvalid;
        ARLEN       = 8'd63;
        ARSIZE      = 3'b011;
        ARBURST     = 2'b01;
        ARCACHE     = 4'b1111;
        ARPROT      = 3'b010;
        // Room for the whole burst was checked before AR, so data flows straight through
        RREADY      = w_in_data & m_ready;
        m_valid     = w_in_data & RVALID;
        m_data      = RDATA;
        m_sof       = w_in_data & RVALID & (r_addr_offset == 32'd0) & (r_beat_count == 6'd0);
        reader_done = (r_state == FRAME_END);
        rresp_err   = r_rresp_err;
        rlast_err   = r_rlast_err;
        state       = r_state;
        ADDR_OFFSET = r_addr_offset;
    end

    // -----------------------------------------------------------------------------------------
    // FSM and datapath registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk_100Mhz) begin
        if (!rst_n) begin
            r_state           <= IDLE;
            r_start_d         <= 1'b0;
            r_buf_select      <= 1'b0;
            r_active          <= 1'b0;
            r_restart_pending <= 1'b0;
            r_restart_buf     <= 1'b0;
            r_addr_offset     <= 32'd0;
            r_araddr          <= AXI_ADDR_WIDTH'(BASE_BUF0);
            r_arvalid         <= 1'b0;
            r_beat_count      <= 6'd0;
            r_rresp_err       <= 1'b0;
            r_rlast_err       <= 1'b0;
        end else begin
            r_start_d <= start_frame;

            case (r_state)
                IDLE: begin
                    r_araddr <= AXI_ADDR_WIDTH'(w_base + r_addr_offset);
                    if (w_start_edge) begin
                        r_buf_select  <= buf_select;
                        r_active      <= 1'b1;
                        r_addr_offset <= 32'd0;
                    end
                    // Hold off one cycle on a fresh edge so ARADDR picks up the new base/offset
                    if (r_active && room_ok && !w_start_edge) begin
                        r_state   <= ADDR_SEND;
                        r_arvalid <= 1'b1;
                    end
                end

                ADDR_SEND: begin
                    if (w_start_edge) begin
                        r_restart_pending <= 1'b1;
                        r_restart_buf     <= buf_select;
                    end
                    if (ARREADY) begin
                        r_arvalid    <= 1'b0;
                        r_beat_count <= 6'd0;
                        r_state      <= DATA_RECV;
                    end
                end

                DATA_RECV: begin
                    if (w_start_edge) begin
                        r_restart_pending <= 1'b1;
                        r_restart_buf     <= buf_select;
                    end
                    if (w_beat) begin
                        r_beat_count <= r_beat_count + 6'd1;
                        if (RRESP != 2'b00) begin
                            r_rresp_err <= 1'b1;
                        end
                        // RLAST must appear on beat 63 and nowhere else
                        if (RLAST != (r_beat_count == LAST_BEAT)) begin
                            r_rlast_err <= 1'b1;
                        end
                    end
                    // The burst length is fixed, so the beat count ends it, not RLAST
                    if (w_burst_end) begin
                        if (r_addr_offset == LAST_OFFSET) begin
                            r_state <= FRAME_END;
                        end else if (w_restart) begin
                            r_state           <= IDLE;
                            r_active          <= 1'b1;
                            r_addr_offset     <= 32'd0;
                            r_buf_select      <= w_restart_buf;
                            r_restart_pending <= 1'b0;
                        end else begin
                            r_state       <= IDLE;
                            r_addr_offset <= r_addr_offset + BURST_BYTES;
                        end
                    end
                end

                FRAME_END: begin
                    r_state       <= IDLE;
                    r_active      <= 1'b0;
                    r_addr_offset <= 32'd0;
                    // A request arriving now (or held over) re-arms instead of idling
                    if (w_restart) begin
                        r_active          <= 1'b1;
                        r_buf_select      <= w_restart_buf;
                        r_restart_pending <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_frame_reader.sv
// ---------------------------------------------------------------------------------------------
// tb_axi4_frame_reader
//
// Bench for axi4_frame_reader. A reactive AXI slave returns address-derived data with random
// RVALID gaps and optional ARREADY delay, RLAST/RRESP fault injection, while m_ready is
// randomized. A frame-level model tracks which frame byte each beat must carry.
// ---------------------------------------------------------------------------------------------
module tb_axi4_frame_reader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n       = 1'b0;
    logic        start_frame = 1'b0;
    logic        buf_select  = 1'b0;
    logic        room_ok     = 1'b1;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY     = 1'b0;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [3:0]  ARCACHE;
    logic [2:0]  ARPROT;
    logic [63:0] RDATA       = 64'd0;
    logic [1:0]  RRESP       = 2'b00;
    logic        RLAST       = 1'b0;
    logic        RVALID      = 1'b0;
    logic        RREADY;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_ready     = 1'b1;
    logic        m_sof;
    logic        reader_done;
    logic        rresp_err;
    logic        rlast_err;
    logic [1:0]  state;
    logic [31:0] ADDR_OFFSET;

    axi4_frame_reader #(
        .AXI_ADDR_WIDTH (32),
        .AXI_DATA_WIDTH (64),
        .FRAME_BYTES    (153600)
    ) u_dut (
        .clk_100Mhz  (clk),
        .rst_n       (rst_n),
        .start_frame (start_frame),
        .buf_select  (buf_select),
        .room_ok     (room_ok),
        .ARADDR      (ARADDR),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .ARLEN       (ARLEN),
        .ARSIZE      (ARSIZE),
        .ARBURST     (ARBURST),
        .ARCACHE     (ARCACHE),
        .ARPROT      (ARPROT),
        .RDATA       (RDATA),
        .RRESP       (RRESP),
        .RLAST       (RLAST),
        .RVALID      (RVALID),
        .RREADY      (RREADY),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_sof       (m_sof),
        .reader_done (reader_done),
        .rresp_err   (rresp_err),
        .rlast_err   (rlast_err),
        .state       (state),
        .ADDR_OFFSET (ADDR_OFFSET)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory content seen by the reader: each 8-byte word encodes its own byte address
    function automatic logic [63:0] beat_word(input logic [31:0] addr);
        return {addr, addr ^ 32'hA5A5_5A5A};
    endfunction

    // Slave / stimulus configuration
    int          ar_delay       = 0;
    int          rvalid_pct     = 100;
    int          mready_pct     = 100;
    logic [31:0] inj_rlast_addr = 32'd0;
    logic [31:0] inj_rresp_addr = 32'd0;

    // Frame-level reference model: frame base, burst index in frame, beats taken in burst
    logic        mdl_restart_pend = 1'b0;
    logic [31:0] mdl_restart_base = 32'd0;
    logic [31:0] mdl_base         = 32'd0;
    int          mdl_burst        = 0;
    int          mdl_beats        = 64;

    int          ar_count   = 0;
    int          beat_total = 0;
    int          sof_count  = 0;
    int          done_count = 0;
    logic [31:0] first_ar   = 32'd0;
    logic [31:0] last_ar    = 32'd0;

    // Sample on the falling edge, react 1 ns after the rising edge
    initial begin : bus
        logic        s_rst;
        logic        ar_hs;
        logic        r_hs;
        logic        m_hs;
        logic        s_arvalid;
        logic [31:0] s_araddr;
        logic        ar_wait_prev;
        logic [31:0] prev_araddr;
        logic        in_burst;
        logic [31:0] a;
        logic [31:0] s_q[$];
        int          s_beat;
        int          s_cnt;
        s_beat       = 0;
        s_cnt        = 0;
        ar_wait_prev = 1'b0;
        prev_araddr  = 32'd0;
        forever begin
            @(negedge clk);
            s_rst     = rst_n;
            s_arvalid = ARVALID;
            s_araddr  = ARADDR;
            ar_hs     = ARVALID && ARREADY;
            r_hs      = RVALID && RREADY;
            m_hs      = m_valid && m_ready;
            in_burst  = (mdl_beats < 64);

            check_eq("rready", RREADY, in_burst && m_ready);
            check_eq("m_valid", m_valid, in_burst && RVALID);
            if (ar_wait_prev) begin
                check_eq("arvalid_hold", ARVALID, 1);
                check_eq("araddr_hold", ARADDR, prev_araddr);
            end
            if (reader_done) done_count++;

            if (!s_rst) begin
                mdl_beats        = 64;
                mdl_burst        = 0;
                mdl_restart_pend = 1'b0;
                ar_wait_prev     = 1'b0;
            end else begin
                if (m_hs) begin
                    check_eq("beat_in_burst", in_burst, 1);
                    a = mdl_base + 32'(mdl_burst) * 32'd512 + 32'(mdl_beats) * 32'd8;
                    check_eq("m_data", m_data, beat_word(a));
                    check_eq("m_sof", m_sof, (mdl_burst == 0) && (mdl_beats == 0));
                    if (m_sof) sof_count++;
                    beat_total++;
                    mdl_beats++;
                end
                if (ar_hs) begin
                    check_eq("beats_per_burst", mdl_beats, 64);
                    if (mdl_restart_pend) begin
                        mdl_base         = mdl_restart_base;
                        mdl_burst        = 0;
                        mdl_restart_pend = 1'b0;
                    end else begin
                        mdl_burst++;
                    end
                    mdl_beats = 0;
                    check_eq("araddr", s_araddr, mdl_base + 32'(mdl_burst) * 32'd512);
                    check_eq("addr_offset", ADDR_OFFSET, 32'(mdl_burst) * 32'd512);
                    if (ar_count == 0) first_ar = s_araddr;
                    last_ar = s_araddr;
                    ar_count++;
                end
                ar_wait_prev = s_arvalid && !ARREADY;
                prev_araddr  = s_araddr;
            end

            @(posedge clk);
            #1;
            if (!s_rst) begin
                s_q.delete();
                s_beat  = 0;
                s_cnt   = 0;
                ARREADY = 1'b0;
                RVALID  = 1'b0;
                RLAST   = 1'b0;
                RRESP   = 2'b00;
            end else begin
                if (ar_hs) s_q.push_back(s_araddr);
                if (r_hs) begin
                    s_beat++;
                    if (s_beat == 64) begin
                        void'(s_q.pop_front());
                        s_beat = 0;
                    end
                end
                if (ar_hs || !s_arvalid) begin
                    s_cnt   = 0;
                    ARREADY = (ar_delay == 0);
                end else begin
                    s_cnt++;
                    ARREADY = (s_cnt >= ar_delay);
                end
                // An offered beat stays put until accepted
                if (!(RVALID && !r_hs)) begin
                    if (s_q.size() > 0 && $urandom_range(99) < rvalid_pct) begin
                        a      = s_q[0] + 32'(s_beat) * 32'd8;
                        RVALID = 1'b1;
                        RDATA  = beat_word(a);
                        RLAST  = (s_q[0] == inj_rlast_addr) ? (s_beat == 32) : (s_beat == 63);
                        RRESP  = (s_q[0] == inj_rresp_addr && s_beat == 5) ? 2'b10 : 2'b00;
                    end else begin
                        RVALID = 1'b0;
                        RLAST  = 1'b0;
                        RRESP  = 2'b00;
                    end
                end
            end
            m_ready = ($urandom_range(99) < mready_pct);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ar(input int n, input int limit, input string tag);
        int c = 0;
        while (ar_count < n && c < limit) begin
            tick(1);
            c++;
        end
        check_eq(tag, ar_count >= n, 1);
    endtask

    task automatic wait_done(input int n, input int limit, input string tag);
        int c = 0;
        while (done_count < n && c < limit) begin
            tick(1);
            c++;
        end
        check_eq(tag, done_count >= n, 1);
    endtask

    task automatic pulse_start(input logic sel, input logic [31:0] base);
        buf_select       = sel;
        mdl_restart_base = base;
        mdl_restart_pend = 1'b1;
        start_frame      = 1'b1;
        tick(1);
        start_frame      = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_arvalid"}, ARVALID, 0);
        check_eq({pfx, "_araddr"}, ARADDR, 32'h0110_0000);
        check_eq({pfx, "_rready"}, RREADY, 0);
        check_eq({pfx, "_m_valid"}, m_valid, 0);
        check_eq({pfx, "_m_sof"}, m_sof, 0);
        check_eq({pfx, "_done"}, reader_done, 0);
        check_eq({pfx, "_rresp_err"}, rresp_err, 0);
        check_eq({pfx, "_rlast_err"}, rlast_err, 0);
        check_eq({pfx, "_state"}, state, 0);
        check_eq({pfx, "_offset"}, ADDR_OFFSET, 0);
    endtask

    initial begin : main
        int lat;
        int c;

        // Reset values and fixed burst attributes
        tick(3);
        check_reset_outputs("rst");
        check_eq("arlen", ARLEN, 63);
        check_eq("arsize", ARSIZE, 3'b011);
        check_eq("arburst", ARBURST, 2'b01);
        check_eq("arcache", ARCACHE, 4'b1111);
        check_eq("arprot", ARPROT, 3'b010);
        rst_n = 1'b1;
        tick(1);

        // Frame A: buffer 1, ideal slave, also measure edge-to-ARVALID latency
        buf_select       = 1'b1;
        mdl_restart_base = 32'h0100_0000;
        mdl_restart_pend = 1'b1;
        start_frame      = 1'b1;
        lat = 0;
        while (!ARVALID && lat < 10) begin
            tick(1);
            lat++;
            start_frame = 1'b0;
        end
        check_eq("start_to_arvalid", lat, 2);
        wait_done(1, 25000, "a_done_seen");
        tick(5);
        check_eq("a_done_count", done_count, 1);
        check_eq("a_ar_count", ar_count, 300);
        check_eq("a_beats", beat_total, 19200);
        check_eq("a_sof_count", sof_count, 1);
        check_eq("a_first_ar", first_ar, 32'h0100_0000);
        check_eq("a_last_ar", last_ar, 32'h0102_5600);
        check_eq("a_rresp_err", rresp_err, 0);
        check_eq("a_rlast_err", rlast_err, 0);
        check_eq("a_state", state, 0);
        check_eq("a_offset", ADDR_OFFSET, 0);

        // Frame B: buffer 0, slow ARREADY, random handshakes, room_ok pause, injected faults
        ar_count       = 0;
        beat_total     = 0;
        sof_count      = 0;
        done_count     = 0;
        ar_delay       = 5;
        rvalid_pct     = 85;
        mready_pct     = 75;
        inj_rlast_addr = 32'h0110_0000 + 32'd20 * 32'd512;
        inj_rresp_addr = 32'h0110_0000 + 32'd25 * 32'd512;
        pulse_start(1'b0, 32'h0110_0000);
        wait_ar(10, 3000, "b_wait_ar10");
        room_ok = 1'b0;
        check_eq("b_rlast_err_clean", rlast_err, 0);
        check_eq("b_rresp_err_clean", rresp_err, 0);
        c = 0;
        while (!(mdl_burst == 9 && mdl_beats >= 64) && c < 2000) begin
            tick(1);
            c++;
        end
        check_eq("b_burst9_done", mdl_burst == 9 && mdl_beats >= 64, 1);
        tick(50);
        check_eq("b_pause_ar_count", ar_count, 10);
        check_eq("b_pause_arvalid", ARVALID, 0);
        check_eq("b_pause_offset", ADDR_OFFSET, 32'h1400);
        check_eq("b_pause_state", state, 0);
        room_ok = 1'b1;
        wait_done(1, 50000, "b_done_seen");
        tick(5);
        check_eq("b_done_count", done_count, 1);
        check_eq("b_ar_count", ar_count, 300);
        check_eq("b_beats", beat_total, 19200);
        check_eq("b_sof_count", sof_count, 1);
        check_eq("b_first_ar", first_ar, 32'h0110_0000);
        check_eq("b_last_ar", last_ar, 32'h0112_5600);
        check_eq("b_rresp_err", rresp_err, 1);
        check_eq("b_rlast_err", rlast_err, 1);

        // Restart mid-burst at offset 0x800, then reset mid-burst
        ar_count       = 0;
        beat_total     = 0;
        sof_count      = 0;
        done_count     = 0;
        ar_delay       = 0;
        rvalid_pct     = 100;
        mready_pct     = 100;
        inj_rlast_addr = 32'd0;
        inj_rresp_addr = 32'd0;
        pulse_start(1'b1, 32'h0100_0000);
        wait_ar(5, 1000, "r_wait_ar5");
        tick(10);
        check_eq("r_mid_state", state, 2);
        check_eq("r_mid_offset", ADDR_OFFSET, 32'h0800);
        pulse_start(1'b0, 32'h0110_0000);
        wait_ar(6, 500, "r_wait_ar6");
        check_eq("r_restart_ar", last_ar, 32'h0110_0000);
        check_eq("r_restart_offset", ADDR_OFFSET, 0);
        wait_ar(7, 500, "r_wait_ar7");
        tick(20);
        check_eq("r_pre_reset_state", state, 2);
        rst_n = 1'b0;
        tick(1);
        check_reset_outputs("mid_rst");
        rst_n = 1'b1;
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
